// File: rtl/vga_binary_renderer_if.sv
// Pixel-stream bundle between the display controller side and the binary renderer.
// The renderer consumes position/visibility plus operands and returns the pixel colour.
interface vga_binary_renderer_if #(
    parameter int N_CH  = 3,
    parameter int WIDTH = 16
);
    logic                    bright;
    logic [9:0]              hCount;
    logic [9:0]              vCount;
    logic [N_CH*WIDTH-1:0]   data;
    logic [2:0]              sel;
    logic                    sel_en;
    logic [11:0]             rgb;

    modport master (
        output bright, hCount, vCount, data, sel, sel_en,
        input  rgb
    );

    modport slave (
        input  bright, hCount, vCount, data, sel, sel_en,
        output rgb
    );
endinterface

// File: rtl/vga_binary_renderer.sv
// Draws N_CH operand rows as 10x10 binary glyphs, MSB leftmost, with per-frame
// operand snapshot, optional blinking highlight, and a fixed 2-cycle pixel pipeline.
module vga_binary_renderer #(
    parameter int          N_CH         = 3,
    parameter int          WIDTH        = 16,
    parameter int          H_START      = 200,
    parameter int          V_START      = 100,
    parameter int          V_PITCH      = 50,
    parameter logic [11:0] FG           = 12'h000,
    parameter logic [11:0] BG           = 12'hFFF,
    parameter logic [11:0] HL           = 12'hF00,
    parameter int          BLINK_FRAMES = 30
) (
    input logic                 clk,
    input logic                 rst,
    vga_binary_renderer_if.slave bus
);
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [N_CH*WIDTH-1:0] shadow;
    logic [CW-1:0]         frame_cnt;
    logic                  phase;
    logic                  boundary;

    int                    h_int;
    int                    v_int;
    int                    h_rel;
    int                    v_rel;
    logic                  in_cols;
    logic [9:0]            cell_shift;
    logic [WIDTH-1:0]      word;
    logic                  hit;
    logic                  bit_val;
    logic [3:0]            col;
    logic [3:0]            row;
    logic                  hl;

    logic                  s1_bright;
    logic                  s1_hit;
    logic                  s1_bit;
    logic [3:0]            s1_col;
    logic [3:0]            s1_row;
    logic                  s1_hl;

    assign boundary = (bus.hCount == 10'd0) && (bus.vCount == 10'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= '0;
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (boundary) begin
            shadow <= bus.data;
            if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Regions never overlap because V_PITCH >= 10, so at most one channel hits.
    always_comb begin
        h_int      = int'(bus.hCount);
        v_int      = int'(bus.vCount);
        h_rel      = h_int - H_START;
        in_cols    = (h_rel >= 0) && (h_rel < 10 * WIDTH);
        cell_shift = 10'(h_rel / 10);
        v_rel      = 0;
        word       = '0;
        hit        = 1'b0;
        bit_val    = 1'b0;
        col        = 4'(h_rel % 10);
        row        = 4'd0;
        hl         = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            v_rel = v_int - (V_START + k * V_PITCH);
            if (in_cols && (v_rel >= 0) && (v_rel < 10)) begin
                hit     = 1'b1;
                row     = 4'(v_rel);
                word    = shadow[k*WIDTH +: WIDTH] << cell_shift;
                bit_val = word[WIDTH-1];
                hl      = bus.sel_en && (bus.sel == 3'(k)) && phase;
            end
        end
    end

    function automatic logic glyph_lit(input logic b, input logic [3:0] c, input logic [3:0] r);
        if (r < 4'd1 || r > 4'd8 || c < 4'd1 || c > 4'd8) return 1'b0;
        if (b) return (c == 4'd4) || (c == 4'd5);
        if (r <= 4'd2 || r >= 4'd7) return (c >= 4'd3) && (c <= 4'd6);
        return (c <= 4'd2) || (c >= 4'd7);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_bright <= 1'b0;
            s1_hit    <= 1'b0;
            s1_bit    <= 1'b0;
            s1_col    <= 4'd0;
            s1_row    <= 4'd0;
            s1_hl     <= 1'b0;
            bus.rgb   <= 12'h000;
        end else begin
            s1_bright <= bus.bright;
            s1_hit    <= hit;
            s1_bit    <= bit_val;
            s1_col    <= col;
            s1_row    <= row;
            s1_hl     <= hl;
            if (!s1_bright)
                bus.rgb <= 12'h000;
            else if (s1_hit && glyph_lit(s1_bit, s1_col, s1_row))
                bus.rgb <= s1_hl ? HL : FG;
            else
                bus.rgb <= BG;
        end
    end
endmodule

// File: tb/tb_vga_binary_renderer.sv
// Directed bench for vga_binary_renderer: vector table for glyph/geometry checks
// plus sequences for reset, latency, frame snapshot and blink behaviour.
module tb_vga_binary_renderer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_binary_renderer_if #(.N_CH(3), .WIDTH(16)) bus ();

    vga_binary_renderer #(.N_CH(3), .WIDTH(16), .BLINK_FRAMES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        b;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [17];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic b);
        bus.hCount = h;
        bus.vCount = v;
        bus.bright = b;
    endtask

    task automatic probe(input string name, input logic [9:0] h, input logic [9:0] v,
                         input logic b, input logic [11:0] exp);
        pix(h, v, b);
        repeat (2) @(posedge clk);
        #1;
        chk(name, bus.rgb, exp);
    endtask

    task automatic frame_edge();
        pix(10'd0, 10'd0, 1'b0);
        @(posedge clk);
        #1;
        pix(10'd500, 10'd500, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{10'd204, 10'd101, 1'b1, 12'h000};
        vecs[1]  = '{10'd214, 10'd101, 1'b1, 12'h000};
        vecs[2]  = '{10'd211, 10'd101, 1'b1, 12'hFFF};
        vecs[3]  = '{10'd209, 10'd101, 1'b1, 12'hFFF};
        vecs[4]  = '{10'd360, 10'd101, 1'b1, 12'hFFF};
        vecs[5]  = '{10'd204, 10'd110, 1'b1, 12'hFFF};
        vecs[6]  = '{10'd204, 10'd100, 1'b1, 12'hFFF};
        vecs[7]  = '{10'd204, 10'd101, 1'b0, 12'h000};
        vecs[8]  = '{10'd201, 10'd153, 1'b1, 12'hFFF};
        vecs[9]  = '{10'd215, 10'd155, 1'b1, 12'h000};
        vecs[10] = '{10'd212, 10'd204, 1'b1, 12'h000};
        vecs[11] = '{10'd355, 10'd208, 1'b1, 12'h000};
        vecs[12] = '{10'd353, 10'd203, 1'b1, 12'hFFF};
        vecs[13] = '{10'd343, 10'd208, 1'b1, 12'h000};
        vecs[14] = '{10'd199, 10'd101, 1'b1, 12'hFFF};
        vecs[15] = '{10'd250, 10'd160, 1'b1, 12'hFFF};
        vecs[16] = '{10'd359, 10'd101, 1'b1, 12'hFFF};

        rst        = 1'b1;
        bus.sel    = 3'd0;
        bus.sel_en = 1'b0;
        bus.data   = '0;
        pix(10'd500, 10'd500, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rgb", bus.rgb, 12'h000);
        rst = 1'b0;

        bus.data = {16'h0001, 16'hFFFF, 16'h8000};
        frame_edge();
        for (int i = 0; i < 17; i++)
            probe($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].b, vecs[i].exp);

        // Exact 2-cycle latency on bright using an unlit in-region pixel.
        probe("lat_pre", 10'd211, 10'd101, 1'b1, 12'hFFF);
        pix(10'd211, 10'd101, 1'b0);
        @(posedge clk); #1;
        chk("lat_off_c1", bus.rgb, 12'hFFF);
        @(posedge clk); #1;
        chk("lat_off_c2", bus.rgb, 12'h000);
        pix(10'd211, 10'd101, 1'b1);
        @(posedge clk); #1;
        chk("lat_on_c1", bus.rgb, 12'h000);
        @(posedge clk); #1;
        chk("lat_on_c2", bus.rgb, 12'hFFF);

        // Mid-frame operand change must wait for the next frame boundary.
        probe("snap_pre", 10'd204, 10'd153, 1'b1, 12'h000);
        bus.data[31:16] = 16'h0000;
        probe("snap_hold", 10'd204, 10'd153, 1'b1, 12'h000);
        frame_edge();
        probe("snap_new1", 10'd204, 10'd153, 1'b1, 12'hFFF);
        probe("snap_new0", 10'd214, 10'd151, 1'b1, 12'h000);

        // Reset mid-frame on a pixel lit only if ch0 MSB is '1'.
        probe("rst_pre", 10'd204, 10'd103, 1'b1, 12'h000);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("rst_hold%0d", c), bus.rgb, 12'h000);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_rel_c1", bus.rgb, 12'h000);
        @(posedge clk); #1;
        chk("rst_rel_c2", bus.rgb, 12'hFFF);

        // Blink with BLINK_FRAMES=2: highlight during frames 2-3, plain in 1 and 4-5.
        bus.data   = {16'h0000, 16'hFFFF, 16'hFFFF};
        bus.sel    = 3'd1;
        bus.sel_en = 1'b1;
        for (int f = 1; f <= 6; f++) begin
            frame_edge();
            probe($sformatf("blink_ch1_f%0d", f), 10'd204, 10'd153, 1'b1,
                  (f == 2 || f == 3 || f == 6) ? 12'hF00 : 12'h000);
            probe($sformatf("blink_ch0_f%0d", f), 10'd204, 10'd103, 1'b1, 12'h000);
        end
        probe("blink_unlit", 10'd201, 10'd153, 1'b1, 12'hFFF);
        bus.sel = 3'd3;
        probe("blink_sel3", 10'd204, 10'd153, 1'b1, 12'h000);
        bus.sel    = 3'd1;
        bus.sel_en = 1'b0;
        probe("blink_en0", 10'd204, 10'd153, 1'b1, 12'h000);
        bus.sel_en = 1'b1;
        probe("blink_en1", 10'd204, 10'd153, 1'b1, 12'hF00);
        bus.sel = 3'd0;
        probe("blink_sel0", 10'd204, 10'd103, 1'b1, 12'hF00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
